// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receiver, transmitter and auth logic.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

    localparam int BAUD_DIV_50M_19200 = 2604;

    localparam logic [7:0] CMD_GO   = 8'h67;
    localparam logic [7:0] CMD_STOP = 8'h73;

endpackage

// File: rtl/rx_bit_timer.sv
// 12-bit down-counter with synchronous reload; tc is high while the count is zero.
module rx_bit_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [11:0] load_val,
    output logic        tc
);

    logic [11:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 12'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_fc.sv
// 8N1 UART receiver with glitch rejection, framing/overrun flags and rdy/clr_rdy handshake.
// Optional macro UART_RX_MAJ_VOTE_EN: 2-of-3 majority per bit decision, +1 cycle latency.
module uart_rx_fc
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_50M_19200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err
);

    localparam int          HALF_DIV    = BAUD_DIV / 2;
    localparam logic [11:0] BAUD_RELOAD = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_RELOAD = 12'(HALF_DIV - 1);

    logic        rx_ff1_q, rx_s_q, rx_prev_q;
    rx_state_t   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  idx_q, idx_d;
    logic        rdy_q, rdy_d;
    logic        frm_q, frm_d;
    logic        ovr_q, ovr_d;
    logic        tmr_load;
    logic [11:0] tmr_val;
    logic        tmr_tc;
    logic        fall;
    logic        in_frame;
    logic        bits_done;
    logic        bit_ev;
    logic        bit_val;

    // rx_prev_q runs in every state so a start edge right after STOP is not lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1_q  <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_ff1_q  <= RX;
            rx_s_q    <= rx_ff1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall      = rx_prev_q & ~rx_s_q;
    assign in_frame  = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign bits_done = (idx_q == 3'd7);

    rx_bit_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

`ifdef UART_RX_MAJ_VOTE_EN
    // Timer reloads at terminal count; the decision lands one cycle later once the tc+1 sample exists.
    logic pend_q, pend_d;
    logic maj_a_q, maj_a_d;
    logic maj_b_q, maj_b_d;

    always_comb begin
        pend_d  = in_frame & tmr_tc;
        maj_a_d = maj_a_q;
        maj_b_d = maj_b_q;
        if (pend_d) begin
            maj_a_d = rx_prev_q;
            maj_b_d = rx_s_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= 1'b0;
            maj_a_q <= 1'b1;
            maj_b_q <= 1'b1;
        end else begin
            pend_q  <= pend_d;
            maj_a_q <= maj_a_d;
            maj_b_q <= maj_b_d;
        end
    end

    assign bit_ev  = pend_q;
    assign bit_val = (maj_a_q & maj_b_q) | (maj_a_q & rx_s_q) | (maj_b_q & rx_s_q);
`else
    assign bit_ev  = tmr_tc;
    assign bit_val = rx_s_q;
`endif

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        data_d   = data_q;
        idx_d    = idx_q;
        rdy_d    = rdy_q & ~clr_rdy;
        frm_d    = 1'b0;
        ovr_d    = 1'b0;
        tmr_load = in_frame & tmr_tc;
        tmr_val  = BAUD_RELOAD;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    tmr_load = 1'b1;
                    tmr_val  = HALF_RELOAD;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_ev) begin
                    if (bit_val) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (bit_ev) begin
                    shift_d = {bit_val, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (bits_done) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_ev) begin
                    if (bit_val) begin
                        data_d  = shift_q;
                        rdy_d   = 1'b1;
                        ovr_d   = rdy_q & ~clr_rdy;
                        state_d = IDLE;
                    end else begin
                        frm_d   = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            rdy_q   <= 1'b0;
            frm_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            rdy_q   <= rdy_d;
            frm_q   <= frm_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data = data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_q;
    assign ovr_err = ovr_q;

endmodule
